// File: rtl/vca_pkg.sv
// Shared types and constants for the vca_mul amplifier stage and its serial multiplier.
package vca_pkg;

    localparam int          GAIN_W     = 16;
    localparam logic [15:0] GAIN_UNITY = 16'hFFFF;
    localparam int          MUL_CYCLES = 16;
    localparam int          CNT_W      = $clog2(MUL_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2
    } state_t;

endpackage

// File: rtl/vca_mul_serial_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, LSB first, over MUL_CYCLES cycles.
// done is asserted during the final cycle and product already includes that cycle's add.
module serial_mul
    import vca_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 a_signed,
    input  logic [AW-1:0]        a,
    input  logic [GAIN_W-1:0]    b,
    output logic                 done,
    output logic [AW+GAIN_W-1:0] product
);

    localparam int PW = AW + GAIN_W;

    logic [PW-1:0]     mcand_reg;
    logic [PW-1:0]     acc_reg;
    logic [GAIN_W-1:0] mplier_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              busy_reg;
    logic [PW-1:0]     acc_next;
    logic              ext_bit;

    assign ext_bit  = a_signed & a[AW-1];
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign done     = busy_reg && (cnt_reg == CNT_W'(MUL_CYCLES - 1));
    assign product  = acc_next;

    // Accumulation is modulo 2^PW, so the same adder serves signed and unsigned operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            mcand_reg  <= {{GAIN_W{ext_bit}}, a};
            acc_reg    <= '0;
            mplier_reg <= b;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vca_mul.sv
// Serial VCA: scales a signed sample by envelope gain env[31:16] (Q0.16).
// Define VCA_EXP_CURVE_EN to square the gain first (quasi-exponential loudness curve).
module vca_mul
    import vca_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   env,
    input  logic          in_valid,
    input  logic [DW-1:0] in_sample,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_sample,
    output logic [7:0]    drop_cnt
);

    localparam int AW = (DW > GAIN_W) ? DW : GAIN_W;
    localparam int PW = AW + GAIN_W;

    state_t            state_reg;
    logic [DW-1:0]     sample_reg;
    logic [DW-1:0]     out_sample_reg;
    logic              bypass_reg;
    logic              out_valid_reg;
    logic [7:0]        drop_cnt_reg;

    logic [GAIN_W-1:0] env_gain;
    logic              accept;
    logic              mul_start;
    logic              mul_signed;
    logic              mul_done;
    logic [AW-1:0]     mul_a;
    logic [GAIN_W-1:0] mul_b;
    logic [PW-1:0]     mul_p;
    logic [DW-1:0]     scaled;
    logic              spare_unused;

    assign env_gain     = env[31:16];
    assign accept       = in_valid && (state_reg == IDLE);
    assign scaled       = mul_p[GAIN_W +: DW];
    assign spare_unused = ^{env[GAIN_W-1:0], mul_p[GAIN_W-1:0]};

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = out_valid_reg;
    assign out_sample = out_sample_reg;
    assign drop_cnt   = drop_cnt_reg;

`ifdef VCA_EXP_CURVE_EN
    // Acceptance squares the gain; the SQR result feeds straight into the MUL pass.
    always_comb begin
        mul_start  = accept || ((state_reg == SQR) && mul_done);
        mul_a      = AW'(env_gain);
        mul_b      = env_gain;
        mul_signed = 1'b0;
        if (state_reg == SQR) begin
            mul_a      = AW'($signed(sample_reg));
            mul_b      = mul_p[GAIN_W +: GAIN_W];
            mul_signed = 1'b1;
        end
    end
`else
    always_comb begin
        mul_start  = accept;
        mul_a      = AW'($signed(in_sample));
        mul_b      = env_gain;
        mul_signed = 1'b1;
    end
`endif

    serial_mul #(
        .AW(AW)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a_signed(mul_signed),
        .a       (mul_a),
        .b       (mul_b),
        .done    (mul_done),
        .product (mul_p)
    );

    // Bypass samples still run the multiplier so latency is identical to the normal path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            sample_reg     <= '0;
            bypass_reg     <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_sample_reg <= '0;
            drop_cnt_reg   <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            if (in_valid && (state_reg != IDLE) && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sample_reg <= in_sample;
                        bypass_reg <= (env_gain == GAIN_UNITY);
`ifdef VCA_EXP_CURVE_EN
                        state_reg  <= SQR;
`else
                        state_reg  <= MUL;
`endif
                    end
                end
`ifdef VCA_EXP_CURVE_EN
                SQR: begin
                    if (mul_done) begin
                        state_reg <= MUL;
                    end
                end
`endif
                MUL: begin
                    if (mul_done) begin
                        state_reg      <= IDLE;
                        out_valid_reg  <= 1'b1;
                        out_sample_reg <= bypass_reg ? sample_reg : scaled;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vca_mul.sv
// Self-checking bench for vca_mul: randomized samples against an arithmetic gain model.
module tb_vca_mul;

`ifdef VCA_EXP_CURVE_EN
    localparam int LAT = 33;
    localparam bit EXP = 1'b1;
`else
    localparam int LAT = 17;
    localparam bit EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] env;
    logic        in_valid;
    logic [15:0] in_sample;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_sample;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    vca_mul #(.DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .env       (env),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sample(out_sample),
        .drop_cnt  (drop_cnt)
    );

    // floor(sample * gain / 65536), gain squared first in the exp-curve build; unity gain passes through.
    function automatic logic [15:0] model(input logic [31:0] e, input logic [15:0] s);
        longint g, geff, p, q;
        g = longint'(e[31:16]);
        if (g == 65535) return s;
        geff = EXP ? (g * g) / 65536 : g;
        p = longint'($signed(s)) * geff;
        q = p / 65536;
        if (p < 0 && (p % 65536) != 0) q = q - 1;
        return q[15:0];
    endfunction

    // Returns at the falling edge just after the accepting rising edge.
    task automatic send(input logic [31:0] e, input logic [15:0] s);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        env       = e;
        in_sample = s;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic wait_out(input int lat0, output int lat, output logic [15:0] v);
        lat = lat0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        v = out_sample;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; env = '0; in_sample = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_sample !== 16'd0) begin errors++; $display("FAIL reset_out_sample got %h want 0000", out_sample); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        $display("reset: in_ready=%b out_valid=%b out_sample=%h drop_cnt=%0d", in_ready, out_valid, out_sample, drop_cnt);
    endtask

    task automatic test_scaling;
        logic [31:0] e_tab [4] = '{32'h80000000, 32'h80000000, 32'h0000FFFF, 32'h00000000};
        logic [15:0] s_tab [4] = '{16'd1000, 16'hFC18, 16'hFFFF, 16'h8000};
        for (int i = 0; i < 20; i++) begin
            logic [31:0] e;
            logic [15:0] s, v, exp_v;
            int lat;
            if (i < 4) begin e = e_tab[i]; s = s_tab[i]; end
            else begin e = $urandom; s = 16'($urandom); end
            exp_v = model(e, s);
            send(e, s);
            wait_out(1, lat, v);
            checks++; if (v !== exp_v) begin errors++; $display("FAIL scale_value env=%h in=%0d got %0d want %0d", e, $signed(s), $signed(v), $signed(exp_v)); end
            checks++; if (lat !== LAT) begin errors++; $display("FAIL scale_latency env=%h got %0d want %0d", e, lat, LAT); end
            $display("scale: env=%h in=%0d out=%0d latency=%0d", e, $signed(s), $signed(v), lat);
        end
    endtask

    task automatic test_bypass;
        logic [31:0] e_tab [3] = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF1234};
        logic [15:0] s_tab [3] = '{16'h8000, 16'd1000, 16'h7FFF};
        for (int i = 0; i < 3; i++) begin
            logic [15:0] v;
            int lat;
            send(e_tab[i], s_tab[i]);
            wait_out(1, lat, v);
            checks++; if (v !== s_tab[i]) begin errors++; $display("FAIL bypass_value got %0d want %0d", $signed(v), $signed(s_tab[i])); end
            checks++; if (lat !== LAT) begin errors++; $display("FAIL bypass_latency got %0d want %0d", lat, LAT); end
            $display("bypass: env=%h in=%0d out=%0d latency=%0d", e_tab[i], $signed(s_tab[i]), $signed(v), lat);
        end
    endtask

    task automatic test_env_change;
        logic [15:0] v, exp_v;
        int lat;
        exp_v = model(32'h80000000, 16'd1000);
        send(32'h80000000, 16'd1000);
        @(negedge clk);
        env = 32'h0;
        wait_out(2, lat, v);
        checks++; if (v !== exp_v) begin errors++; $display("FAIL env_change_value got %0d want %0d", $signed(v), $signed(exp_v)); end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL env_change_latency got %0d want %0d", lat, LAT); end
        $display("env_change: out=%0d latency=%0d", $signed(v), lat);
    endtask

    task automatic test_back_to_back;
        int accepts, exp_drop, outs, exp_outs, n;
        logic [15:0] exp_v;
        accepts  = (40 + LAT - 1) / LAT;
        exp_drop = 40 - accepts;
        exp_outs = 39 / LAT;
        exp_v    = model(32'h40000000, 16'd400);
        outs     = 0;
        @(negedge clk);
        env = 32'h40000000; in_sample = 16'd400; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic exp_rdy;
            exp_rdy = (i % LAT == 0);
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready cycle=%0d got %b want %b", i, in_ready, exp_rdy); end
            if (out_valid) begin
                outs++;
                checks++; if (out_sample !== exp_v) begin errors++; $display("FAIL b2b_value cycle=%0d got %0d want %0d", i, $signed(out_sample), $signed(exp_v)); end
                $display("b2b: cycle=%0d out=%0d", i, $signed(out_sample));
            end
            @(negedge clk);
        end
        checks++; if (outs !== exp_outs) begin errors++; $display("FAIL b2b_out_count got %0d want %0d", outs, exp_outs); end
        checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL b2b_drop_cnt got %0d want %0d", drop_cnt, exp_drop); end
        $display("b2b: after 40 cycles drop_cnt=%0d", drop_cnt);
        repeat (300) @(negedge clk);
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_saturate got %0d want 255", drop_cnt); end
        $display("b2b: after 340 cycles drop_cnt=%0d", drop_cnt);
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_no_wrap got %0d want 255", drop_cnt); end
    endtask

    task automatic test_reset_mid;
        int seen, lat;
        logic [15:0] v, exp_v;
        send(32'h80000000, 16'd1000);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        checks++; if (out_sample !== 16'd0) begin errors++; $display("FAIL midrst_out_sample got %h want 0000", out_sample); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL midrst_drop_cnt got %0d want 0", drop_cnt); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_output got %0d pulses want 0", seen); end
        $display("reset_mid: stray pulses=%0d", seen);
        exp_v = model(32'h80000000, 16'd1000);
        send(32'h80000000, 16'd1000);
        wait_out(1, lat, v);
        checks++; if (v !== exp_v) begin errors++; $display("FAIL midrst_next_value got %0d want %0d", $signed(v), $signed(exp_v)); end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL midrst_next_latency got %0d want %0d", lat, LAT); end
        $display("reset_mid: next out=%0d latency=%0d", $signed(v), lat);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; env = '0; in_sample = '0;
        test_reset;
        test_scaling;
        test_bypass;
        test_env_change;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
